// File: rtl/kronos_branch_seq.sv
// Multi-cycle branch comparator. Operands are compared CHUNK bits per
// cycle from the most significant slice down. The walk stops at the first
// slice that differs, so the latency depends on the data.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; operands and op are latched on req_valid
// CMP   | comparing slice idx_q; leaves on the first difference or at idx 0
// DONE  | result/branch presented with resp_valid until resp_ready or flush
module kronos_branch_seq #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rstz,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            branch,
    output logic [1:0]      result
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

    localparam logic [1:0] RES_EQ = 2'b00;
    localparam logic [1:0] RES_LT = 2'b01;
    localparam logic [1:0] RES_GT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [1:0]        result_q, result_d;
    logic              branch_q, branch_d;

    logic [CHUNK-1:0]  sl_a, sl_b;

    // Branch decision from funct3 and the final relation; 010/011 fall
    // into the default arm and behave as a less-than branch.
    function automatic logic taken(input logic [2:0] f3, input logic [1:0] rel);
        case (f3)
            3'b000:         taken = (rel == RES_EQ);
            3'b001:         taken = (rel != RES_EQ);
            3'b101, 3'b111: taken = (rel != RES_LT);
            default:        taken = (rel == RES_LT);
        endcase
    endfunction

    // Select the current slice; for signed ops flip the sign bit of the top
    // slice so an unsigned compare orders two's-complement values correctly.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IW'(i)) begin
                sl_a = rs1_q[i*CHUNK +: CHUNK];
                sl_b = rs2_q[i*CHUNK +: CHUNK];
            end
        end
        if (!op_q[1] && (idx_q == IDX_TOP)) begin
            sl_a[CHUNK-1] = ~sl_a[CHUNK-1];
            sl_b[CHUNK-1] = ~sl_b[CHUNK-1];
        end
    end

    // Next-state logic; result/branch only change on the entry into DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        result_d = result_q;
        branch_d = branch_q;
        case (state_q)
            IDLE: begin
                if (!flush && req_valid) begin
                    op_d    = op;
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                    idx_d   = IDX_TOP;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (flush) begin
                    idx_d   = IDX_TOP;
                    state_d = IDLE;
                end else if (sl_a < sl_b) begin
                    result_d = RES_LT;
                    branch_d = taken(op_q, RES_LT);
                    state_d  = DONE;
                end else if (sl_a > sl_b) begin
                    result_d = RES_GT;
                    branch_d = taken(op_q, RES_GT);
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    result_d = RES_EQ;
                    branch_d = taken(op_q, RES_EQ);
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (flush || resp_ready) begin
                    idx_d   = IDX_TOP;
                    state_d = IDLE;
                end
            end
            default: begin
                idx_d   = IDX_TOP;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q  <= IDLE;
            idx_q    <= IDX_TOP;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= RES_EQ;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign result     = result_q;
    assign branch     = branch_q;

endmodule
